// File: rtl/mmio_gpio_hub.sv
// Memory-mapped GPIO block for the CPU IO window.
// Switch inputs pass through a two-flop synchroniser and a per-bit debouncer.
// Each switch bit has a sticky change flag (write 1 to clear).
// The block also holds an LED output register and a level interrupt.
module mmio_gpio_hub #(
  parameter int unsigned SW_WIDTH   = 24,
  parameter int unsigned LED_WIDTH  = 24,
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 io_sel,
  input  logic                 ioread,
  input  logic                 iowrite,
  input  logic [3:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [SW_WIDTH-1:0]  switch_i,
  output logic [LED_WIDTH-1:0] ledout,
  output logic                 irq
);

  localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [1:0] REG_SW   = 2'd0;
  localparam logic [1:0] REG_LED  = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  logic [SW_WIDTH-1:0]             sync1;
  logic [SW_WIDTH-1:0]             sync2;
  logic [SW_WIDTH-1:0]             deb;
  logic [SW_WIDTH-1:0]             deb_nxt;
  logic [SW_WIDTH-1:0]             sw_edge;
  logic [SW_WIDTH-1:0]             edge_nxt;
  logic [SW_WIDTH-1:0]             w1c;
  logic [SW_WIDTH-1:0][CNT_W-1:0]  cnt;
  logic [SW_WIDTH-1:0][CNT_W-1:0]  cnt_nxt;
  logic [LED_WIDTH-1:0]            led_q;
  logic                            irq_en;
  logic                            wr_en;
  logic                            rd_en;
  logic                            unused_bus;

  assign wr_en = io_sel & iowrite;
  assign rd_en = io_sel & ioread;

  // The byte-lane address bits and the upper write-data bits are not decoded.
  assign unused_bus = ^{addr[1:0], wdata};

  // Debounce: a level must differ from the debounced value for DEB_CYCLES cycles.
  always_comb begin
    deb_nxt = deb;
    cnt_nxt = '0;
    for (int i = 0; i < int'(SW_WIDTH); i++) begin
      if (sync2[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sticky change flags: a new flip on a bit wins over a clear of that bit.
  always_comb begin
    w1c      = '0;
    if (wr_en && (addr[3:2] == REG_EDGE)) begin
      w1c = wdata[SW_WIDTH-1:0];
    end
    edge_nxt = (sw_edge & ~w1c) | (deb ^ deb_nxt);
  end

  // Synchroniser, debounce state and change flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      cnt     <= '0;
      sw_edge <= '0;
    end else begin
      sync1   <= switch_i;
      sync2   <= sync1;
      deb     <= deb_nxt;
      cnt     <= cnt_nxt;
      sw_edge <= edge_nxt;
    end
  end

  // Bus-writable registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_q  <= '0;
      irq_en <= 1'b0;
    end else if (wr_en) begin
      if (addr[3:2] == REG_LED) begin
        led_q <= wdata[LED_WIDTH-1:0];
      end
      if (addr[3:2] == REG_CTRL) begin
        irq_en <= wdata[0];
      end
    end
  end

  // Zero-latency read mux; idle bus reads as zero.
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (addr[3:2])
        REG_SW:   rdata = 32'(deb);
        REG_LED:  rdata = 32'(led_q);
        REG_EDGE: rdata = 32'(sw_edge);
        REG_CTRL: rdata = {31'b0, irq_en};
        default:  rdata = '0;
      endcase
    end
  end

  assign ledout = led_q;
  assign irq    = irq_en & (|sw_edge);

endmodule

// File: tb/tb_mmio_gpio_hub.sv
// Scoreboard bench for mmio_gpio_hub: default instance plus a 32/8/1 instance.
module tb_mmio_gpio_hub;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel_a, sel_b, ioread, iowrite;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [23:0] sw_a;
  logic [31:0] sw_b;
  logic [31:0] rdata_a, rdata_b;
  logic [23:0] led_a;
  logic [7:0]  led_b;
  logic        irq_a, irq_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic [31:0] led;
    logic        irq;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  mmio_gpio_hub #(.SW_WIDTH(24), .LED_WIDTH(24), .DEB_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .io_sel(sel_a), .ioread(ioread), .iowrite(iowrite),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .switch_i(sw_a),
    .ledout(led_a), .irq(irq_a)
  );

  mmio_gpio_hub #(.SW_WIDTH(32), .LED_WIDTH(8), .DEB_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .io_sel(sel_b), .ioread(ioread), .iowrite(iowrite),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .switch_i(sw_b),
    .ledout(led_b), .irq(irq_b)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every active read pops one expected entry for that instance.
  always @(negedge clk) begin
    exp_t e;
    if (sel_a && ioread) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_read: got 0x%08h expected no read", rdata_a);
      end else begin
        e = q_a.pop_front();
        chk({e.nm, "/rdata"}, rdata_a, e.rd);
        chk({e.nm, "/ledout"}, 32'(led_a), e.led);
        chk({e.nm, "/irq"}, {31'b0, irq_a}, {31'b0, e.irq});
      end
    end
    if (sel_b && ioread) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_read: got 0x%08h expected no read", rdata_b);
      end else begin
        e = q_b.pop_front();
        chk({e.nm, "/rdata"}, rdata_b, e.rd);
        chk({e.nm, "/ledout"}, 32'(led_b), e.led);
        chk({e.nm, "/irq"}, {31'b0, irq_b}, {31'b0, e.irq});
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bus cycle; reads push their expected response before the cycle starts.
  task automatic bus(input bit to_b, input bit r, input bit w, input logic [3:0] a,
                     input logic [31:0] d, input string nm, input logic [31:0] er,
                     input logic [31:0] el, input logic ei);
    exp_t e;
    sel_a   = !to_b;
    sel_b   = to_b;
    ioread  = r;
    iowrite = w;
    addr    = a;
    wdata   = d;
    if (r) begin
      e.nm = nm; e.rd = er; e.led = el; e.irq = ei;
      if (to_b) q_b.push_back(e);
      else      q_a.push_back(e);
    end
    @(posedge clk);
    #1;
    sel_a = 1'b0; sel_b = 1'b0; ioread = 1'b0; iowrite = 1'b0;
  endtask

  task automatic rd_a(input logic [3:0] a, input string nm, input logic [31:0] er,
                      input logic [31:0] el, input logic ei);
    bus(1'b0, 1'b1, 1'b0, a, 32'h0, nm, er, el, ei);
  endtask

  task automatic wr_a(input logic [3:0] a, input logic [31:0] d);
    bus(1'b0, 1'b0, 1'b1, a, d, "", 32'h0, 32'h0, 1'b0);
  endtask

  task automatic rd_b(input logic [3:0] a, input string nm, input logic [31:0] er,
                      input logic [31:0] el, input logic ei);
    bus(1'b1, 1'b1, 1'b0, a, 32'h0, nm, er, el, ei);
  endtask

  task automatic wr_b(input logic [3:0] a, input logic [31:0] d);
    bus(1'b1, 1'b0, 1'b1, a, d, "", 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset with switches high and an LED write pending.
    rst = 1'b0; sw_a = 24'hFFFFFF; sw_b = 32'h0;
    sel_a = 1'b1; sel_b = 1'b0; ioread = 1'b0; iowrite = 1'b1;
    addr = 4'h4; wdata = 32'hFFFF_FFFF;
    tick(2);
    sel_a = 1'b0; iowrite = 1'b0;
    rd_a(4'h0, "rst_sw",   32'h0, 32'h0, 1'b0);
    rd_a(4'h4, "rst_led",  32'h0, 32'h0, 1'b0);
    rd_a(4'h8, "rst_edge", 32'h0, 32'h0, 1'b0);
    rd_a(4'hC, "rst_ctrl", 32'h0, 32'h0, 1'b0);

    // Release: switches become visible at the sixth edge.
    rst = 1'b1;
    tick(5);
    rd_a(4'h0, "deb_pending",  32'h0,        32'h0, 1'b0);
    rd_a(4'h0, "deb_released", 32'h00FFFFFF, 32'h0, 1'b0);
    rd_a(4'h8, "edge_all",     32'h00FFFFFF, 32'h0, 1'b0);
    wr_a(4'h8, 32'hFFFF_FFFF);
    rd_a(4'h8, "edge_cleared", 32'h0, 32'h0, 1'b0);

    // Bring switches back low and clear the resulting flags.
    sw_a = 24'h0;
    tick(6);
    wr_a(4'h8, 32'hFFFF_FFFF);
    rd_a(4'h0, "sw_low",           32'h0, 32'h0, 1'b0);
    rd_a(4'h8, "edge_low_cleared", 32'h0, 32'h0, 1'b0);

    // LED register and read-only switch register.
    wr_a(4'h4, 32'hDEAD_BEEF);
    rd_a(4'h4, "led_rw", 32'h00ADBEEF, 32'h00ADBEEF, 1'b0);
    wr_a(4'h0, 32'h1234_5678);
    rd_a(4'h0, "sw_ro", 32'h0, 32'h00ADBEEF, 1'b0);

    // Bit 3 rises and stays; bit 5 pulses for three cycles.
    sw_a = 24'h000028;
    tick(3);
    sw_a = 24'h000008;
    tick(2);
    rd_a(4'h0, "bit3_early", 32'h0, 32'h00ADBEEF, 1'b0);
    rd_a(4'h0, "bit3_set",   32'h8, 32'h00ADBEEF, 1'b0);
    rd_a(4'h8, "bit3_edge",  32'h8, 32'h00ADBEEF, 1'b0);
    tick(3);
    rd_a(4'h0, "glitch_ignored", 32'h8, 32'h00ADBEEF, 1'b0);

    // Interrupt enable and W1C.
    wr_a(4'hC, 32'h1);
    rd_a(4'hC, "irq_en", 32'h1, 32'h00ADBEEF, 1'b1);
    wr_a(4'h8, 32'h8);
    rd_a(4'h8, "w1c", 32'h0, 32'h00ADBEEF, 1'b0);

    // Clear lands on the same edge as bit 3 falling: the set wins.
    sw_a = 24'h0;
    tick(5);
    wr_a(4'h8, 32'h8);
    rd_a(4'h8, "set_beats_clr", 32'h8, 32'h00ADBEEF, 1'b1);
    rd_a(4'h0, "bit3_fell",     32'h0, 32'h00ADBEEF, 1'b1);

    // Read and write in the same cycle return the old value.
    bus(1'b0, 1'b1, 1'b1, 4'h4, 32'h0000_0055, "rd_during_wr", 32'h00ADBEEF, 32'h00ADBEEF, 1'b1);
    rd_a(4'h4, "led_after_wr", 32'h55, 32'h55, 1'b1);

    // Reset in the middle of a debounce on bit 0.
    sw_a = 24'h000001;
    tick(3);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    rd_a(4'h0, "mid_rst_sw",   32'h0, 32'h0, 1'b0);
    rd_a(4'h4, "mid_rst_led",  32'h0, 32'h0, 1'b0);
    rd_a(4'hC, "mid_rst_ctrl", 32'h0, 32'h0, 1'b0);
    tick(2);
    rd_a(4'h0, "restart_pending", 32'h0, 32'h0, 1'b0);
    rd_a(4'h0, "restart_done",    32'h1, 32'h0, 1'b0);
    rd_a(4'h8, "restart_edge",    32'h1, 32'h0, 1'b0);

    // Second instance: full 32-bit switches, 8-bit LEDs, single-cycle debounce.
    sw_b = 32'hF0F0_0001;
    tick(2);
    rd_b(4'h0, "b_pending", 32'h0,         32'h0, 1'b0);
    rd_b(4'h0, "b_sw32",    32'hF0F0_0001, 32'h0, 1'b0);
    rd_b(4'h8, "b_edge32",  32'hF0F0_0001, 32'h0, 1'b0);
    wr_b(4'h4, 32'hDEAD_BEEF);
    rd_b(4'h4, "b_led8", 32'h0000_00EF, 32'h0000_00EF, 1'b0);
    wr_b(4'h8, 32'hF0F0_0001);
    rd_b(4'h8, "b_w1c", 32'h0, 32'h0000_00EF, 1'b0);

    tick(1);
    chk("a_queue_drained", 32'(q_a.size()), 32'h0);
    chk("b_queue_drained", 32'(q_b.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
